memory_wait: RTL and testbench
==============================

Name: memory_wait

Overview:
Dual-port byte-addressed RAM for the SoC. Port A is a word-only, read-only instruction-fetch port. Port B is a read/write data port with byte, halfword and word accesses. Each port has a req/ready handshake and a one-cycle response pulse after a parametrised latency, so cores can be tested against slow memories.

Parameters:
N, 4096, memory size in bytes; must be a power of two and at least 4.
LATENCY, 1, cycles from accept to response, per port; legal range 1..15.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
a_req  input  1  port A fetch request.
a_addr  input  32  port A byte address.
a_ready  output  1  port A can accept a request this cycle.
a_rvalid  output  1  port A response pulse.
a_rdata  output  32  port A read data; valid only with a_rvalid.
a_err  output  1  port A error; valid only with a_rvalid.
b_req  input  1  port B request.
b_write  input  1  port B direction: 1 = write, 0 = read.
b_tsize  input  tsize_e  port B access size: BYTE, HALFWORD or WORD.
b_addr  input  32  port B byte address.
b_wdata  input  32  port B write data; uses bits [7:0], [15:0] or [31:0] according to size.
b_ready  output  1  port B can accept a request this cycle.
b_rvalid  output  1  port B response pulse, for both reads and writes.
b_rdata  output  32  port B read data, zero-extended; 0 for writes.
b_err  output  1  port B error; valid only with b_rvalid.

Behaviour:
- Storage: N bytes, little-endian. Memory contents are not reset.
- Reset (rst_n low at a clock edge): both FSMs go to IDLE; counters, rvalid, rdata and err all go to 0. A pending transaction is dropped and produces no response. A write already committed stays in memory.
- Per-port FSM: IDLE, WAIT, RESP.
  - ready = (state == IDLE) or (state == RESP).
  - Accept = req and ready at a rising edge.
  - On accept with LATENCY = 1: go to RESP.
  - On accept with LATENCY > 1: go to WAIT and load cnt = LATENCY-2.
  - WAIT: if cnt == 0 go to RESP, otherwise decrement cnt.
  - RESP: rvalid = 1 for exactly one cycle. A new accept in RESP is handled as from IDLE, giving back-to-back throughput of one transaction per LATENCY cycles. With no accept, return to IDLE.
  - Result: a request accepted at edge E produces rvalid in the cycle after edge E+LATENCY-1.
- No response backpressure; the requester must take rvalid when it is asserted.
- Capture at accept:
  - Read data is sampled from memory at the accept edge and held in a response register until RESP.
  - Writes commit to memory at the accept edge.
  - Request inputs are don't-care after accept.
- Errors: err = 1 in the response cycle when any of the following holds.
  - Port A: a_addr[1:0] is not 0.
  - Port B: WORD with addr[1:0] not 0; HALFWORD with addr[0] = 1; b_tsize not BYTE, HALFWORD or WORD.
  - The address range check described under Optional Feature fails.
- On error: memory is not modified and rdata = 0.
- Same-edge collision, port A read and port B write to overlapping bytes: port A returns the old data.
- Port B read accepted at the edge immediately after a port B write to the same address returns the new data.
- Ports are fully independent; there is no arbitration and neither port stalls the other.

Optional Feature:
Macro MEM_ADDR_CHECK_EN.
- Defined: any access with addr + size - 1 >= N gives err = 1, no write and rdata = 0.
- Undefined: only the low $clog2(N) address bits are used, so addresses wrap modulo N with no range error.

Test Plan:
1. LATENCY = 1, B writes WORD 0xDEADBEEF to 0x10, then B reads WORD 0x10 -> each b_rvalid comes the cycle after accept; rdata = 0xDEADBEEF, err = 0.
2. LATENCY = 3, A fetches 0x10 -> a_ready low for 2 cycles, a_rvalid in the cycle after edge E+2; rdata = 0xDEADBEEF. Holding a_req continuously gives one response every 3 cycles.
3. B HALFWORD write 0xABCD at 0x12, then BYTE read 0x13 -> 0x000000AB. HALFWORD read at 0x11 -> err = 1, rdata = 0, memory unchanged.
4. Same-edge A fetch of 0x20 (old value 0x11111111) and B WORD write 0x22222222 to 0x20 -> A returns 0x11111111; a later A fetch returns 0x22222222.
5. LATENCY = 4, rst_n low for one edge during WAIT -> no rvalid ever appears; ready = 1 the cycle after reset.
6. N = 4096, B WORD read at 0x1000 -> with MEM_ADDR_CHECK_EN: err = 1. Without it: returns the data stored at 0x0.

Source files
------------

// File: rtl/memory_wait.sv
// memory_wait: dual-port byte RAM, A = word fetch port, B = byte/half/word data port, with parametrised response latency.
// Define MEM_ADDR_CHECK_EN to flag accesses past N as errors; otherwise addresses wrap modulo N.
module memory_wait_port #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    output logic ready_o,
    output logic accept_o,
    output logic rvalid_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] LOAD = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    assign ready_o  = state_q != WAIT;
    assign accept_o = req_i & ready_o & rst_n;
    assign rvalid_o = state_q == RESP;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept_o) begin
            state_d = LATENCY == 1 ? RESP : WAIT;
            cnt_d   = LOAD;
        end else if (state_q == WAIT) begin
            state_d = cnt_q == 4'd0 ? RESP : WAIT;
            cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

module memory_wait #(
    parameter int N       = 4096,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [31:0] a_addr,
    output logic        a_ready,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_write,
    input  logic [1:0]  b_tsize,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ready,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err
);
    localparam int AW = $clog2(N);
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    logic [7:0] mem_q [N];
    logic a_accept, b_accept;
    logic a_range_bad, b_range_bad, a_bad, b_bad, b_align_bad;
    logic [AW-1:0] a_idx, b_idx0, b_idx1, b_idx2, b_idx3;
    logic [31:0] a_word, b_rd;
    logic [31:0] a_rdata_q, b_rdata_q;
    logic a_err_q, b_err_q;
    logic [1:0] b_size_m1;
    memory_wait_port #(.LATENCY(LATENCY)) u_port_a (
        .clk(clk), .rst_n(rst_n), .req_i(a_req),
        .ready_o(a_ready), .accept_o(a_accept), .rvalid_o(a_rvalid)
    );
    memory_wait_port #(.LATENCY(LATENCY)) u_port_b (
        .clk(clk), .rst_n(rst_n), .req_i(b_req),
        .ready_o(b_ready), .accept_o(b_accept), .rvalid_o(b_rvalid)
    );
    assign b_size_m1 = b_tsize == SZ_WORD ? 2'd3 : b_tsize == SZ_HALF ? 2'd1 : 2'd0;
`ifdef MEM_ADDR_CHECK_EN
    assign a_range_bad = ({1'b0, a_addr} + 33'd3) >= 33'(N);
    assign b_range_bad = ({1'b0, b_addr} + {31'd0, b_size_m1}) >= 33'(N);
`else
    logic unused_addr;
    assign unused_addr = ^{a_addr, b_addr};
    assign a_range_bad = 1'b0;
    assign b_range_bad = 1'b0;
`endif
    assign a_idx  = a_addr[AW-1:0];
    assign a_bad  = (a_addr[1:0] != 2'd0) | a_range_bad;
    assign a_word = {mem_q[a_idx + AW'(3)], mem_q[a_idx + AW'(2)], mem_q[a_idx + AW'(1)], mem_q[a_idx]};
    assign b_idx0 = b_addr[AW-1:0];
    assign b_idx1 = b_idx0 + AW'(1);
    assign b_idx2 = b_idx0 + AW'(2);
    assign b_idx3 = b_idx0 + AW'(3);
    assign b_align_bad = (b_tsize == SZ_WORD & b_addr[1:0] != 2'd0) | (b_tsize == SZ_HALF & b_addr[0]);
    assign b_bad = b_align_bad | (b_tsize == 2'd3) | b_range_bad;
    assign b_rd = b_tsize == SZ_WORD ? {mem_q[b_idx3], mem_q[b_idx2], mem_q[b_idx1], mem_q[b_idx0]} :
                  b_tsize == SZ_HALF ? {16'd0, mem_q[b_idx1], mem_q[b_idx0]} :
                  {24'd0, mem_q[b_idx0]};
    // Writes land at the accept edge, so a same-edge port A read still sees the old bytes.
    always_ff @(posedge clk) begin
        if (b_accept & b_write & ~b_bad) begin
            mem_q[b_idx0] <= b_wdata[7:0];
            if (b_tsize != SZ_BYTE) mem_q[b_idx1] <= b_wdata[15:8];
            if (b_tsize == SZ_WORD) begin
                mem_q[b_idx2] <= b_wdata[23:16];
                mem_q[b_idx3] <= b_wdata[31:24];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rdata_q <= 32'd0;
            a_err_q   <= 1'b0;
            b_rdata_q <= 32'd0;
            b_err_q   <= 1'b0;
        end else begin
            if (a_accept) begin
                a_rdata_q <= a_bad ? 32'd0 : a_word;
                a_err_q   <= a_bad;
            end
            if (b_accept) begin
                b_rdata_q <= (b_bad | b_write) ? 32'd0 : b_rd;
                b_err_q   <= b_bad;
            end
        end
    end
    assign a_rdata = a_rdata_q;
    assign a_err   = a_err_q;
    assign b_rdata = b_rdata_q;
    assign b_err   = b_err_q;
endmodule

// File: tb/tb_memory_wait.sv
// tb_memory_wait: directed checks of memory_wait at LATENCY 1 (u1) and LATENCY 3 (u3).
module tb_memory_wait;
    localparam logic [1:0] SZB = 2'd0;
    localparam logic [1:0] SZH = 2'd1;
    localparam logic [1:0] SZW = 2'd2;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    logic r1_n, a1_req, a1_ready, a1_rvalid, a1_err, b1_req, b1_write, b1_ready, b1_rvalid, b1_err;
    logic [1:0] b1_tsize;
    logic [31:0] a1_addr, a1_rdata, b1_addr, b1_wdata, b1_rdata;
    logic r3_n, a3_req, a3_ready, a3_rvalid, a3_err, b3_req, b3_write, b3_ready, b3_rvalid, b3_err;
    logic [1:0] b3_tsize;
    logic [31:0] a3_addr, a3_rdata, b3_addr, b3_wdata, b3_rdata;
    memory_wait #(.N(4096), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(r1_n),
        .a_req(a1_req), .a_addr(a1_addr), .a_ready(a1_ready), .a_rvalid(a1_rvalid),
        .a_rdata(a1_rdata), .a_err(a1_err),
        .b_req(b1_req), .b_write(b1_write), .b_tsize(b1_tsize), .b_addr(b1_addr),
        .b_wdata(b1_wdata), .b_ready(b1_ready), .b_rvalid(b1_rvalid), .b_rdata(b1_rdata), .b_err(b1_err)
    );
    memory_wait #(.N(4096), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(r3_n),
        .a_req(a3_req), .a_addr(a3_addr), .a_ready(a3_ready), .a_rvalid(a3_rvalid),
        .a_rdata(a3_rdata), .a_err(a3_err),
        .b_req(b3_req), .b_write(b3_write), .b_tsize(b3_tsize), .b_addr(b3_addr),
        .b_wdata(b3_wdata), .b_ready(b3_ready), .b_rvalid(b3_rvalid), .b_rdata(b3_rdata), .b_err(b3_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic b1_op(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        b1_req = 1'b1; b1_write = w; b1_tsize = sz; b1_addr = ad; b1_wdata = wd;
        step();
        b1_req = 1'b0;
        chk({tag, ".rvalid"}, b1_rvalid, 1);
        chk({tag, ".rdata"}, b1_rdata, exp_d);
        chk({tag, ".err"}, b1_err, exp_e);
    endtask

    task automatic a1_op(input string tag, input logic [31:0] ad, input logic [31:0] exp_d, input logic exp_e);
        a1_req = 1'b1; a1_addr = ad;
        step();
        a1_req = 1'b0;
        chk({tag, ".rvalid"}, a1_rvalid, 1);
        chk({tag, ".rdata"}, a1_rdata, exp_d);
        chk({tag, ".err"}, a1_err, exp_e);
    endtask

    initial begin
        r1_n = 1'b0; r3_n = 1'b0;
        a1_req = 1'b0; a1_addr = '0; b1_req = 1'b0; b1_write = 1'b0; b1_tsize = SZW; b1_addr = '0; b1_wdata = '0;
        a3_req = 1'b0; a3_addr = '0; b3_req = 1'b0; b3_write = 1'b0; b3_tsize = SZW; b3_addr = '0; b3_wdata = '0;
        step();
        step();
        r1_n = 1'b1; r3_n = 1'b1;
        chk("rst.a_ready", a1_ready, 1);
        chk("rst.b_ready", b1_ready, 1);
        chk("rst.a_rvalid", a1_rvalid, 0);
        chk("rst.b_rvalid", b1_rvalid, 0);
        chk("rst.b_rdata", b1_rdata, 0);
        chk("rst.b_err", b1_err, 0);
        // Word write then read at LATENCY 1, plus one-cycle pulse
        b1_op("wr10", 1'b1, SZW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        step();
        chk("pulse.b_rvalid", b1_rvalid, 0);
        b1_op("rd10", 1'b0, SZW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        // Sub-word accesses and alignment errors
        b1_op("wrh12", 1'b1, SZH, 32'h12, 32'h0000ABCD, 32'h0, 1'b0);
        b1_op("rdb13", 1'b0, SZB, 32'h13, 32'h0, 32'h000000AB, 1'b0);
        b1_op("rdh12", 1'b0, SZH, 32'h12, 32'h0, 32'h0000ABCD, 1'b0);
        b1_op("rdh11", 1'b0, SZH, 32'h11, 32'h0, 32'h0, 1'b1);
        b1_op("wrh11", 1'b1, SZH, 32'h11, 32'h00009999, 32'h0, 1'b1);
        b1_op("rdw10a", 1'b0, SZW, 32'h10, 32'h0, 32'hABCDBEEF, 1'b0);
        b1_op("rdw12", 1'b0, SZW, 32'h12, 32'h0, 32'h0, 1'b1);
        b1_op("badsz", 1'b0, 2'd3, 32'h10, 32'h0, 32'h0, 1'b1);
        b1_op("wrb11", 1'b1, SZB, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0);
        b1_op("rdw10b", 1'b0, SZW, 32'h10, 32'h0, 32'hABCD55EF, 1'b0);
        a1_op("a_mis", 32'h11, 32'h0, 1'b1);
        // Back-to-back write then read of the same word sees the new data
        b1_op("wr30", 1'b1, SZW, 32'h30, 32'h12345678, 32'h0, 1'b0);
        b1_op("rd30", 1'b0, SZW, 32'h30, 32'h0, 32'h12345678, 1'b0);
        // Same-edge collision: A sees old data
        b1_op("wr20", 1'b1, SZW, 32'h20, 32'h11111111, 32'h0, 1'b0);
        a1_req = 1'b1; a1_addr = 32'h20;
        b1_req = 1'b1; b1_write = 1'b1; b1_tsize = SZW; b1_addr = 32'h20; b1_wdata = 32'h22222222;
        step();
        a1_req = 1'b0; b1_req = 1'b0;
        chk("coll.a_rvalid", a1_rvalid, 1);
        chk("coll.a_rdata", a1_rdata, 32'h11111111);
        chk("coll.b_err", b1_err, 0);
        a1_op("a20new", 32'h20, 32'h22222222, 1'b0);
        // Range / wrap at N
        b1_op("wr0", 1'b1, SZW, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
        b1_op("wrffc", 1'b1, SZW, 32'hFFC, 32'h0BADCAFE, 32'h0, 1'b0);
        b1_op("rdbfff", 1'b0, SZB, 32'hFFF, 32'h0, 32'h0000000B, 1'b0);
`ifdef MEM_ADDR_CHECK_EN
        b1_op("rd1000", 1'b0, SZW, 32'h1000, 32'h0, 32'h0, 1'b1);
        a1_op("a1000", 32'h1000, 32'h0, 1'b1);
`else
        b1_op("rd1000", 1'b0, SZW, 32'h1000, 32'h0, 32'hCAFEF00D, 1'b0);
        a1_op("a1000", 32'h1000, 32'hCAFEF00D, 1'b0);
`endif
        // LATENCY 3: write via B, ready low for two cycles
        b3_req = 1'b1; b3_write = 1'b1; b3_tsize = SZW; b3_addr = 32'h10; b3_wdata = 32'hDEADBEEF;
        step();
        b3_req = 1'b0;
        chk("l3wr.ready0", b3_ready, 0);
        chk("l3wr.rvalid0", b3_rvalid, 0);
        step();
        chk("l3wr.ready1", b3_ready, 0);
        chk("l3wr.rvalid1", b3_rvalid, 0);
        step();
        chk("l3wr.rvalid2", b3_rvalid, 1);
        chk("l3wr.ready2", b3_ready, 1);
        chk("l3wr.err", b3_err, 0);
        chk("l3wr.rdata", b3_rdata, 0);
        step();
        // Held fetch request gives one response every 3 cycles
        a3_req = 1'b1; a3_addr = 32'h10;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 5) a3_req = 1'b0;
            chk($sformatf("l3a.rvalid%0d", k), a3_rvalid, (k == 2 || k == 5) ? 1 : 0);
            chk($sformatf("l3a.ready%0d", k), a3_ready, (k == 2 || k == 5) ? 1 : 0);
            if (k == 2 || k == 5) chk($sformatf("l3a.rdata%0d", k), a3_rdata, 32'hDEADBEEF);
        end
        step();
        // Reset during WAIT drops the transaction
        a3_req = 1'b1; a3_addr = 32'h10;
        step();
        a3_req = 1'b0;
        chk("rstw.ready_wait", a3_ready, 0);
        r3_n = 1'b0;
        step();
        r3_n = 1'b1;
        chk("rstw.ready", a3_ready, 1);
        chk("rstw.rvalid", a3_rvalid, 0);
        chk("rstw.rdata", a3_rdata, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rstw.quiet%0d", k), a3_rvalid, 0);
        end
        a3_req = 1'b1; a3_addr = 32'h10;
        step();
        a3_req = 1'b0;
        step();
        step();
        chk("rstw.refetch_rvalid", a3_rvalid, 1);
        chk("rstw.refetch_rdata", a3_rdata, 32'hDEADBEEF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
